controle_contador: RTL

//  Front-end control stage for the 16-state display counter.

---
 rtl/controle_pkg.sv | 4 +
 rtl/controle_contador_debouncer.sv | 59 +++++
 rtl/controle_contador.sv | 37 +++
 3 files changed

// File: rtl/controle_pkg.sv
// controle_pkg: shared debounce state encoding for the counter control stage
package controle_pkg;
  typedef enum logic [1:0] {SOLTO, CONFIRMA_APERTO, APERTADO, CONFIRMA_SOLTO} estado_db_t;
endpackage

// File: rtl/controle_contador_debouncer.sv
// debouncer: 2-FF synchronizer plus press/release confirmation FSM, one-cycle aceito per accepted press
module debouncer
  import controle_pkg::*;
#(
  parameter int N = 500_000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_bruto,
  output logic aceito
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] FIM = W'(N - 1);
  logic s1, s2, aceito_prox;
  estado_db_t estado, prox;
  logic [W-1:0] cnt, cnt_prox;
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      estado <= SOLTO;
      cnt    <= '0;
      aceito <= 1'b0;
    end else begin
      s1     <= btn_bruto;
      s2     <= s1;
      estado <= prox;
      cnt    <= cnt_prox;
      aceito <= aceito_prox;
    end
  always_comb begin
    prox        = estado;
    cnt_prox    = cnt;
    aceito_prox = 1'b0;
    case (estado)
      SOLTO:
        if (s2) begin
          prox     = CONFIRMA_APERTO;
          cnt_prox = '0;
        end
      CONFIRMA_APERTO:
        if (!s2) prox = SOLTO;
        else if (cnt == FIM) begin
          prox        = APERTADO;
          aceito_prox = 1'b1;
        end else cnt_prox = cnt + 1'b1;
      APERTADO:
        if (!s2) begin
          prox     = CONFIRMA_SOLTO;
          cnt_prox = '0;
        end
      CONFIRMA_SOLTO:
        if (s2) prox = APERTADO;
        else if (cnt == FIM) prox = SOLTO;
        else cnt_prox = cnt + 1'b1;
      default: prox = SOLTO;
    endcase
  end
endmodule

// File: rtl/controle_contador.sv
// controle_contador: debounced modo/pausa toggles and prescaled one-cycle passo pulse
module controle_contador #(
  parameter int DEBOUNCE_CICLOS = 500_000,
  parameter int DIV_PASSO       = 50_000_000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_modo,
  input  logic btn_pausa,
  output logic modo,
  output logic pausado,
  output logic passo
);
  localparam int WP = (DIV_PASSO > 1) ? $clog2(DIV_PASSO) : 1;
  localparam logic [WP-1:0] PRE_FIM = WP'(DIV_PASSO - 1);
  logic aceito_modo, aceito_pausa;
  logic [WP-1:0] pre;
  debouncer #(.N(DEBOUNCE_CICLOS)) u_db_modo (
    .clock(clock), .rst(rst), .btn_bruto(btn_modo), .aceito(aceito_modo)
  );
  debouncer #(.N(DEBOUNCE_CICLOS)) u_db_pausa (
    .clock(clock), .rst(rst), .btn_bruto(btn_pausa), .aceito(aceito_pausa)
  );
  // prescaler sees the pre-toggle pausado, so a wrap on the pausing edge still fires
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      modo    <= 1'b0;
      pausado <= 1'b0;
      passo   <= 1'b0;
      pre     <= '0;
    end else begin
      modo    <= modo ^ aceito_modo;
      pausado <= pausado ^ aceito_pausa;
      passo   <= !pausado && pre == PRE_FIM;
      pre     <= pausado ? pre : (pre == PRE_FIM) ? '0 : pre + 1'b1;
    end
endmodule
